uart_rxd: RTL and testbench
===========================

// Module: uart_rxd
// PURPOSE
//   Serial UART receiver, 8N1, LSB first, idle-high line; downstream partner of the 40 kHz UART transmitter.
//   Synchronises bit_in, detects the start bit, samples each bit at mid-period, checks the stop bit.
//   Presents the received byte on dout with a one-cycle dout_valid strobe.
//   A bad stop bit raises a one-cycle frame_err strobe instead.
// PARAMETERS
//   SYS_CLK  40_000   clock frequency in Hz
//   BPS      1000     baud rate
//   BPS_CNT  SYS_CLK/BPS (=40)   clocks per bit; legal range 4..63 (6-bit counter)
// PORTS
//   clk_40k     in   1  system clock, 40 kHz
//   rst_n       in   1  reset, asynchronous, active-low
//   bit_in      in   1  serial line, asynchronous to clk_40k, idle high
//   dout        out  8  last correctly framed byte; held until the next good frame
//   dout_valid  out  1  one-cycle pulse: dout updated this cycle
//   frame_err   out  1  one-cycle pulse: stop bit sampled 0, frame discarded
//   rx_busy     out  1  high while FSM is not in IDLE
// BEHAVIOUR
//   Reset: all sync flops = 1, FSM = IDLE, counters = 0, shift reg = 0, dout = 0.
//     dout_valid = frame_err = rx_busy = 0. Reset mid-frame aborts the frame with no strobe.
//   Sync: 2-FF synchroniser rx_s1 -> rx_s2, plus rx_s3 = previous rx_s2; all reset to 1.
//     Line changes reach rx_s2 two clocks later.
//   Edge: fall = rx_s3 & ~rx_s2, honoured only in IDLE.
//     Cycle E is the cycle fall is seen; the FSM enters START and bit_cnt = 0.
//   bit_cnt (6b) increments every clock outside IDLE and clears on each sample decision.
//     MID = BPS_CNT/2 - 1 (=19).
//   FSM:
//     IDLE  -> START on fall.
//     START -> at bit_cnt==MID, sample. 0: go to DATA, data_idx = 0. 1: false start, go to IDLE, no strobe.
//     DATA  -> at bit_cnt==BPS_CNT-1, sample into shift[data_idx] (LSB first).
//              After data_idx==7 go to STOP; otherwise increment data_idx.
//     STOP  -> at bit_cnt==BPS_CNT-1, sample. 1: dout <= shift, dout_valid = 1. 0: frame_err = 1, dout unchanged.
//              Either way go to IDLE.
//   Sample points: start E+20, data bit k at E+20+40*(k+1), stop at E+380.
//     Strobes are registered, so they go high at E+381 for one cycle.
//   IDLE is re-entered at mid-stop, so a start edge arriving half a bit after the stop
//     centre is accepted. Back-to-back frames need no idle gap.
//   Line stuck low (break): the frame ends with frame_err.
//     Until the line has been high for at least one rx_s2 sample, no new fall occurs, so there is no re-trigger.
//   bit_in toggling while busy is ignored except at sample points.
//   dout_valid and frame_err are never high together.
// CONFIGURATION
//   UART_RX_MAJORITY_EN defined:
//     Each sample is a 2-of-3 vote of rx_s2 at nominal point -1, 0, +1 clock.
//     Decisions, state changes and strobes happen 1 clock later than listed above (strobe at E+382).
//     A single-clock glitch at the sample point is rejected.
//   Undefined: single sample of rx_s2 at the nominal point; no vote logic is instantiated.
// TESTING
//   1 Loopback from the transmitter: din=8'hA5, send_start pulse
//       -> one dout_valid pulse, dout=8'hA5, frame_err never high.
//   2 Back-to-back 8'h00 then 8'hFF
//       -> two dout_valid pulses, dout 8'h00 then 8'hFF, no frame_err.
//   3 bit_in low for 10 clocks, then high
//       -> FSM returns to IDLE at the START sample, rx_busy drops, no strobes.
//   4 Frame 8'h3C with stop bit forced 0 (previous byte 8'h11)
//       -> frame_err pulse at E+381, no dout_valid, dout stays 8'h11.
//   5 rst_n low during data bit 4, then a clean frame 8'h5A
//       -> outputs 0 immediately, no strobe for the aborted frame, then dout=8'h5A with dout_valid.
//   6 Frame 8'hFF with a 1-clock low glitch at the bit-2 sample point
//       -> with UART_RX_MAJORITY_EN dout=8'hFF; without it dout=8'hFB.

Source files
------------

// File: rtl/uart_rxd_if.sv
// uart_rxd_if: receive-side UART signals; the master modport is the line driver/consumer, the slave modport is uart_rxd.
interface uart_rxd_if;
    logic       i_bit_in;
    logic [7:0] o_dout;
    logic       o_dout_valid;
    logic       o_frame_err;
    logic       o_rx_busy;

    modport master (output i_bit_in, input  o_dout, o_dout_valid, o_frame_err, o_rx_busy);
    modport slave  (input  i_bit_in, output o_dout, o_dout_valid, o_frame_err, o_rx_busy);
endinterface

// File: rtl/uart_rxd.sv
// uart_rxd: 8N1 UART receiver, LSB first, mid-bit sampling, stop-bit check; define UART_RX_MAJORITY_EN for a 2-of-3 sample vote.
module uart_rxd #(
    parameter int SYS_CLK = 40_000,
    parameter int BPS     = 1000
) (
    input  logic      clk_40k,
    input  logic      rst_n,
    uart_rxd_if.slave rx
);
    localparam int         BPS_CNT = SYS_CLK / BPS;
    localparam logic [5:0] MID     = 6'(BPS_CNT / 2 - 1);
    localparam logic [5:0] LAST    = 6'(BPS_CNT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t     r_state, w_next;
    logic       r_rx_s1, r_rx_s2, r_rx_s3;
    logic [5:0] r_bit_cnt;
    logic [2:0] r_data_idx;
    logic [7:0] r_shift, r_dout;
    logic       r_dout_valid, r_frame_err;
    logic       w_fall, w_hit, w_dec, w_bit, w_busy, w_good, w_bad;

    // two-flop synchroniser plus one history flop for falling-edge detection
    always_ff @(posedge clk_40k or negedge rst_n)
        if (!rst_n) {r_rx_s1, r_rx_s2, r_rx_s3} <= 3'b111;
        else        {r_rx_s1, r_rx_s2, r_rx_s3} <= {rx.i_bit_in, r_rx_s1, r_rx_s2};

    assign w_fall = (r_state == IDLE) && r_rx_s3 && !r_rx_s2;
    assign w_hit  = (r_state == START) ? (r_bit_cnt == MID)
                  : (r_state != IDLE) && (r_bit_cnt == LAST);

`ifdef UART_RX_MAJORITY_EN
    logic r_rx_s4, r_hit;

    // keep the sample before the nominal point and delay the decision one clock so the point after it is also seen
    always_ff @(posedge clk_40k or negedge rst_n)
        if (!rst_n) begin
            r_rx_s4 <= 1'b1;
            r_hit   <= 1'b0;
        end else begin
            r_rx_s4 <= r_rx_s3;
            r_hit   <= w_hit;
        end

    assign w_dec = r_hit;
    assign w_bit = (r_rx_s2 & r_rx_s3) | (r_rx_s2 & r_rx_s4) | (r_rx_s3 & r_rx_s4);
`else
    assign w_dec = w_hit;
    assign w_bit = r_rx_s2;
`endif

    // state register
    always_ff @(posedge clk_40k or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_fall) w_next = START;
            START:   if (w_dec) w_next = w_bit ? IDLE : DATA;
            DATA:    if (w_dec && r_data_idx == 3'd7) w_next = STOP;
            STOP:    if (w_dec) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FSM outputs: busy flag and the stop-bit verdicts
    always_comb begin
        w_busy = r_state != IDLE;
        w_good = (r_state == STOP) && w_dec && w_bit;
        w_bad  = (r_state == STOP) && w_dec && !w_bit;
    end

    // bit timer; restarting at the nominal sample point keeps bit spacing exact even when the decision is delayed
    always_ff @(posedge clk_40k or negedge rst_n)
        if (!rst_n)                       r_bit_cnt <= '0;
        else if (r_state == IDLE || w_hit) r_bit_cnt <= '0;
        else                              r_bit_cnt <= r_bit_cnt + 6'd1;

    // data bits shift in LSB first, indexed by the bit number
    always_ff @(posedge clk_40k or negedge rst_n)
        if (!rst_n) begin
            r_data_idx <= '0;
            r_shift    <= '0;
        end else if (r_state == START && w_dec) begin
            r_data_idx <= '0;
        end else if (r_state == DATA && w_dec) begin
            r_shift[r_data_idx] <= w_bit;
            r_data_idx          <= r_data_idx + 3'd1;
        end

    // registered result and one-cycle strobes; dout only changes on a good frame
    always_ff @(posedge clk_40k or negedge rst_n)
        if (!rst_n) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_dout_valid <= w_good;
            r_frame_err  <= w_bad;
            if (w_good) r_dout <= r_shift;
        end

    assign rx.o_dout       = r_dout;
    assign rx.o_dout_valid = r_dout_valid;
    assign rx.o_frame_err  = r_frame_err;
    assign rx.o_rx_busy    = w_busy;
endmodule

// File: tb/tb_uart_rxd.sv
// tb_uart_rxd: drives per-cycle line waveforms into uart_rxd and compares every cycle against a frame-timing reference model.
module tb_uart_rxd;
`ifdef UART_RX_MAJORITY_EN
    localparam int M = 1;
`else
    localparam int M = 0;
`endif
    localparam int BIT  = 40;
    localparam int MAXL = 8192;

    logic clk_40k = 1'b0;
    logic rst_n   = 1'b0;

    uart_rxd_if u_if();
    uart_rxd u_dut (.clk_40k(clk_40k), .rst_n(rst_n), .rx(u_if));

    always #5 clk_40k = ~clk_40k;

    logic       ln [MAXL];
    logic       ov [MAXL], oe [MAXL], ob [MAXL];
    logic [7:0] od [MAXL];
    logic       ev [MAXL], ee [MAXL], eb [MAXL];
    logic [7:0] ebyte [MAXL];
    int         len, n_chk, n_pass;
    logic [7:0] dout_ref;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic put(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            ln[len] = v;
            len++;
        end
    endtask

    task automatic frame(input logic [7:0] b, input logic stp);
        put(1'b0, BIT);
        for (int k = 0; k < 8; k++) put(b[k], BIT);
        put(stp, BIT);
    endtask

    // line value bit_in[c] is applied just after clock edge c; outputs are observed mid-cycle
    task automatic run(input int abort);
        for (int c = 0; c < len; c++) begin
            @(posedge clk_40k);
            #1 u_if.i_bit_in = ln[c];
            if (c == abort) begin
                #1 rst_n = 1'b0;
                #1;
                chk("rst_dout", u_if.o_dout, 8'h00);
                chk("rst_valid", u_if.o_dout_valid, 1'b0);
                chk("rst_err", u_if.o_frame_err, 1'b0);
                chk("rst_busy", u_if.o_rx_busy, 1'b0);
                return;
            end
            @(negedge clk_40k);
            ov[c] = u_if.o_dout_valid;
            oe[c] = u_if.o_frame_err;
            ob[c] = u_if.o_rx_busy;
            od[c] = u_if.o_dout;
        end
    endtask

    function automatic logic smp(input int p);
        return (M != 0) ? ((ln[p-1] & ln[p]) | (ln[p-1] & ln[p+1]) | (ln[p] & ln[p+1])) : ln[p];
    endfunction

    function automatic int count_hi(input bit err);
        int n = 0;
        for (int c = 0; c < len; c++) n += err ? int'(oe[c]) : int'(ov[c]);
        return n;
    endfunction

    // reference: a falling line edge at cycle lf seen while idle is a start; bit k is read at lf+20+40k,
    // the verdict lands 2 clocks after that (+1 with voting), the strobe one clock later
    task automatic check_model(input string tag);
        int e, lf, d, mv, me, mb, md;
        logic [7:0] b;
        for (int c = 0; c < len; c++) begin
            ev[c] = 1'b0;
            ee[c] = 1'b0;
            eb[c] = 1'b0;
        end
        e = 3;
        while (e < len) begin
            if (ln[e-3] && !ln[e-2]) begin
                lf = e - 2;
                b  = '0;
                if (smp(lf + 20)) begin
                    d = e + 20 + M;
                end else begin
                    for (int k = 0; k < 8; k++) b[k] = smp(lf + 20 + BIT * (k + 1));
                    d = e + 20 + 9 * BIT + M;
                    if (smp(lf + 20 + 9 * BIT)) ev[d+1] = 1'b1;
                    else ee[d+1] = 1'b1;
                    ebyte[d+1] = b;
                end
                for (int c = e + 1; c <= d; c++) eb[c] = 1'b1;
                e = d + 1;
            end else begin
                e++;
            end
        end
        mv = 0; me = 0; mb = 0; md = 0;
        for (int c = 0; c < len; c++) begin
            if (ev[c]) dout_ref = ebyte[c];
            mv += int'(ov[c] !== ev[c]);
            me += int'(oe[c] !== ee[c]);
            mb += int'(ob[c] !== eb[c]);
            md += int'(od[c] !== dout_ref);
        end
        chk({tag, "/valid_cycles_off"}, mv, 0);
        chk({tag, "/err_cycles_off"}, me, 0);
        chk({tag, "/busy_cycles_off"}, mb, 0);
        chk({tag, "/dout_cycles_off"}, md, 0);
    endtask

    initial begin
        int lf, n;
        logic [7:0] rb;
        n_chk = 0;
        n_pass = 0;
        dout_ref = 8'h00;
        u_if.i_bit_in = 1'b1;
        #22;
        chk("reset_dout", u_if.o_dout, 8'h00);
        chk("reset_valid", u_if.o_dout_valid, 1'b0);
        chk("reset_err", u_if.o_frame_err, 1'b0);
        chk("reset_busy", u_if.o_rx_busy, 1'b0);
        rst_n = 1'b1;

        len = 0; put(1'b1, 8); lf = len; frame(8'hA5, 1'b1); put(1'b1, 400);
        run(-1);
        check_model("a5");
        chk("a5_nvalid", count_hi(1'b0), 1);
        chk("a5_nerr", count_hi(1'b1), 0);
        chk("a5_strobe_time", ov[lf + 383 + M], 1'b1);
        chk("a5_dout", od[len-1], 8'hA5);

        len = 0; put(1'b1, 8); lf = len; frame(8'h00, 1'b1); frame(8'hFF, 1'b1); put(1'b1, 400);
        run(-1);
        check_model("b2b");
        chk("b2b_nvalid", count_hi(1'b0), 2);
        chk("b2b_nerr", count_hi(1'b1), 0);
        chk("b2b_first", od[lf + 383 + M], 8'h00);
        chk("b2b_last", od[len-1], 8'hFF);

        len = 0; put(1'b1, 8); put(1'b0, 10); put(1'b1, 400);
        run(-1);
        check_model("false_start");
        n = 0;
        for (int c = 0; c < len; c++) n += int'(ob[c]);
        chk("false_busy_len", n, 20 + M);
        chk("false_strobes", count_hi(1'b0) + count_hi(1'b1), 0);

        len = 0; put(1'b1, 8); frame(8'h11, 1'b1); lf = len; frame(8'h3C, 1'b0); put(1'b1, 400);
        run(-1);
        check_model("bad_stop");
        chk("bad_stop_err_time", oe[lf + 383 + M], 1'b1);
        chk("bad_stop_nvalid", count_hi(1'b0), 1);
        chk("bad_stop_dout", od[len-1], 8'h11);

        len = 0; put(1'b1, 8); lf = len; frame(8'h77, 1'b1); put(1'b1, 400);
        run(lf + 5 * BIT + 20);
        n = 0;
        for (int c = 0; c < lf + 5 * BIT + 20; c++) n += int'(ov[c]) + int'(oe[c]);
        chk("abort_no_strobe", n, 0);
        u_if.i_bit_in = 1'b1;
        repeat (3) @(posedge clk_40k);
        #2 rst_n = 1'b1;
        dout_ref = 8'h00;
        len = 0; put(1'b1, 8); frame(8'h5A, 1'b1); put(1'b1, 400);
        run(-1);
        check_model("after_reset");
        chk("after_reset_first_dout", od[0], 8'h00);
        chk("after_reset_dout", od[len-1], 8'h5A);
        chk("after_reset_nvalid", count_hi(1'b0), 1);

        len = 0; put(1'b1, 8); lf = len; frame(8'hFF, 1'b1); put(1'b1, 400);
        ln[lf + 20 + 3 * BIT] = 1'b0;
        run(-1);
        check_model("glitch");
        chk("glitch_dout", od[len-1], (M != 0) ? 8'hFF : 8'hFB);

        for (int r = 0; r < 4; r++) begin
            len = 0;
            put(1'b1, 8);
            for (int f = 0; f < 7; f++) begin
                put(1'b1, ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 60));
                if ($urandom_range(0, 7) == 0) begin
                    put(1'b0, $urandom_range(3, 30));
                    put(1'b1, $urandom_range(1, 20));
                end
                lf = len;
                rb = 8'($urandom);
                frame(rb, $urandom_range(0, 5) != 0);
                if ($urandom_range(0, 2) == 0) ln[lf + $urandom_range(0, 399)] ^= 1'b1;
                if ($urandom_range(0, 9) == 0) put(1'b0, $urandom_range(400, 500));
            end
            put(1'b1, 400);
            run(-1);
            check_model($sformatf("random%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
